pipe_accum: RTL and testbench
=============================

// Module: pipe_accum
// PURPOSE
//  Downstream consumer of the y = a*b + c multiply-add pipeline: sums LEN consecutive
//  valid y results into one frame total (dot-product style), then holds it behind a
//  valid/ready output handshake. The upstream valid is delayed 2 cycles to align with y.
// PARAMETERS
//  IN_W   9   width of incoming y sample (unsigned)
//  LEN    4   samples per frame; 2..255
//  ACC_W  11  accumulator/result width; must be >= IN_W + ceil(log2(LEN))
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  start      in   1      1-cycle pulse: open a new frame
//  in_valid   in   1      in_y carries a valid multiply-add result this cycle
//  in_y       in   IN_W   result sample from the multiply-add pipeline
//  out_valid  out  1      out_sum holds a completed frame total
//  out_ready  in   1      consumer accepts out_sum this cycle
//  out_sum    out  ACC_W  frame total, registered
//  busy       out  1      frame in progress (state ACC)
//  drop_err   out  1      sticky: a valid sample arrived while not accepting
// BEHAVIOUR
//  - Reset: state=IDLE, acc=0, cnt=0, out_sum=0, out_valid=0, busy=0, drop_err=0.
//  - All outputs registered; no combinational path input->output.
//  - FSM states IDLE, ACC, DONE:
//    IDLE: start=1 -> ACC; acc<=0, cnt<=0, drop_err<=0. in_valid without start ignored
//          (not an error). start & in_valid same cycle -> sample taken as term 0.
//    ACC : in_valid=1 -> acc<=acc+in_y, cnt<=cnt+1. When in_valid and cnt==LEN-1:
//          out_sum<=acc+in_y, out_valid<=1, acc<=0, cnt<=0, -> DONE.
//          start while in ACC ignored (frame continues). in_valid=0 holds acc/cnt.
//    DONE: out_valid=1, out_sum stable until handshake (out_valid & out_ready).
//          Handshake -> out_valid<=0, -> IDLE; if start also 1 same cycle -> ACC directly
//          (drop_err cleared, a same-cycle in_valid taken as term 0 of new frame).
//          in_valid in DONE without that start -> sample discarded, drop_err<=1.
//  - Latency: out_valid rises the cycle after the LEN-th accepted sample; with the
//    2-cycle multiply-add in front, frame total appears LEN+2 cycles after last a/b/c
//    operands are... counted from first operand: first sample +2, total at +2+LEN.
//  - Width: in_y zero-extended to ACC_W; no overflow possible given ACC_W rule.
//  - busy=1 exactly while state==ACC.
//  - rst mid-frame or mid-DONE: immediate return to reset values; partial sum lost.
// STRUCTURE
//  - Shared package/include: state encodings (ST_IDLE=2'd0, ST_ACC=2'd1, ST_DONE=2'd2),
//    default IN_W/LEN/ACC_W constants shared with the multiply-add stage.
//  - One natural sub-module: frame_counter (LEN-modulo term counter with clear,
//    enable, last-term flag). Accumulator and FSM stay in pipe_accum.
// TESTING
//  1 Reset: rst=1 mid-run -> all outputs 0 same cycle, state IDLE after release.
//  2 Basic frame, LEN=4: start, y=10,20,30,40 back-to-back -> out_valid next cycle,
//    out_sum=100; out_ready=1 -> out_valid 0 following cycle.
//  3 Gapped input: y=5,_,7,_,_,9,11 (gaps in_valid=0) -> out_sum=32, busy=1 throughout.
//  4 Backpressure: out_ready=0 for 5 cycles, in_valid y=3 during DONE -> out_sum=100
//    held stable, sample ignored, drop_err=1; next start clears drop_err.
//  5 Max values: LEN=4, y=511 x4 -> out_sum=2044, no wrap; chained with multiply-add,
//    a=15,b=15,c=15 -> y=240 each -> out_sum=960.
//  6 Back-to-back frames: handshake + start + in_valid(y=1) same cycle -> new frame
//    term 0 taken; next 3 samples y=1 -> out_sum=4.

Source files
------------

// File: rtl/pipe_accum_pkg.sv
// Shared constants and state encodings for the multiply-add pipeline and its frame accumulator.
package pipe_accum_pkg;

    localparam int IN_W_DEF  = 9;
    localparam int LEN_DEF   = 4;
    localparam int ACC_W_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_accum_frame_counter.sv
// LEN-modulo term counter: clear, enable and a flag marking the last term of a frame.
module pipe_accum_frame_counter #(
    parameter int LEN   = 4,
    parameter int CNT_W = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // clr together with en means "new frame, and this cycle's sample is term 0".
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i && en_i) begin
            cnt_d = CNT_W'(1);
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(LEN - 1));

endmodule

// File: rtl/pipe_accum.sv
// Sums LEN valid multiply-add results into one frame total and holds it behind a
// valid/ready handshake; out_sum is transferred on any cycle with out_valid & out_ready.
module pipe_accum
    import pipe_accum_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int LEN   = LEN_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy,
    output logic             drop_err
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_valid_q, out_valid_d;
    logic             drop_err_q, drop_err_d;
    logic             cnt_clr, cnt_en, cnt_last;
    logic [ACC_W-1:0] y_ext;

    assign y_ext = ACC_W'(in_y);

    pipe_accum_frame_counter #(.LEN(LEN)) u_frame_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .last_o(cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        drop_err_d  = drop_err_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ACC;
                    drop_err_d = 1'b0;
                    cnt_clr    = 1'b1;
                    cnt_en     = in_valid;
                    acc_d      = in_valid ? y_ext : '0;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    if (cnt_last) begin
                        out_sum_d   = acc_q + y_ext;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_clr     = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        acc_d  = acc_q + y_ext;
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Handshake plus start chains straight into the next frame.
                if (out_ready && start) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACC;
                    drop_err_d  = 1'b0;
                    cnt_clr     = 1'b1;
                    cnt_en      = in_valid;
                    acc_d       = in_valid ? y_ext : '0;
                end else begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                    if (in_valid) begin
                        drop_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign drop_err  = drop_err_q;
    assign busy      = (state_q == ST_ACC);

endmodule

// File: tb/tb_pipe_accum.sv
// Self-checking bench for pipe_accum: scenario tasks with a frame-total scoreboard queue.
module tb_pipe_accum;
    import pipe_accum_pkg::*;

    localparam int IN_W  = 9;
    localparam int LEN   = 4;
    localparam int ACC_W = 11;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [IN_W-1:0]  in_y;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             busy;
    logic             drop_err;

    int vectors;
    int miscompares;

    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] model_acc;
    int               model_cnt;
    logic [ACC_W-1:0] exp_v;

    pipe_accum #(.IN_W(IN_W), .LEN(LEN), .ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_y     (in_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .busy     (busy),
        .drop_err (drop_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers: inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_frame();
        start = 1'b1;
        model_acc = '0;
        model_cnt = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_y(input logic [IN_W-1:0] y);
        in_valid = 1'b1;
        in_y     = y;
        model_acc = model_acc + ACC_W'(y);
        model_cnt++;
        if (model_cnt == LEN) begin
            exp_q.push_back(model_acc);
            model_acc = '0;
            model_cnt = 0;
        end
        tick();
        in_valid = 1'b0;
        in_y     = '0;
    endtask

    task automatic gap();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_init_valid: got %0b want 0", out_valid); end
        vectors++; if (out_sum !== '0) begin miscompares++; $display("FAIL rst_init_sum: got %0d want 0", out_sum); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_init_busy: got %0b want 0", busy); end
        vectors++; if (drop_err !== 1'b0) begin miscompares++; $display("FAIL rst_init_drop: got %0b want 0", drop_err); end
        #2 rst = 1'b0;
        tick();
        // Reset while a completed frame is held in DONE with drop_err set.
        open_frame();
        drive_y(9'd7); drive_y(9'd7); drive_y(9'd7); drive_y(9'd7);
        in_valid = 1'b1; in_y = 9'd1;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || drop_err !== 1'b1) begin miscompares++; $display("FAIL rst_pre_done: got valid=%0b drop=%0b want 1 1", out_valid, drop_err); end
        rst = 1'b1;
        #1;
        exp_q.delete();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_done_valid: got %0b want 0", out_valid); end
        vectors++; if (out_sum !== '0) begin miscompares++; $display("FAIL rst_done_sum: got %0d want 0", out_sum); end
        vectors++; if (drop_err !== 1'b0) begin miscompares++; $display("FAIL rst_done_drop: got %0b want 0", drop_err); end
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (dut.state_q !== ST_IDLE) begin miscompares++; $display("FAIL rst_done_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        // Reset mid-frame: partial sum must be lost.
        open_frame();
        drive_y(9'd50); drive_y(9'd60);
        rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_acc_busy: got %0b want 0", busy); end
        tick();
        rst = 1'b0;
        model_acc = '0;
        model_cnt = 0;
        tick();
        vectors++; if (dut.state_q !== ST_IDLE) begin miscompares++; $display("FAIL rst_acc_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_basic();
        // in_valid in IDLE without start is ignored and is not an error.
        in_valid = 1'b1; in_y = 9'd99;
        tick();
        in_valid = 1'b0;
        vectors++; if (busy !== 1'b0 || drop_err !== 1'b0) begin miscompares++; $display("FAIL idle_ignore: got busy=%0b drop=%0b want 0 0", busy, drop_err); end
        open_frame();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %0b want 1", busy); end
        drive_y(9'd10); drive_y(9'd20); drive_y(9'd30);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid: got %0b want 0", out_valid); end
        drive_y(9'd40);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_done: got %0b want 0", busy); end
        exp_v = exp_q.pop_front();
        vectors++; if (out_sum !== exp_v) begin miscompares++; $display("FAIL basic_sum: got %0d want %0d", out_sum, exp_v); end
        handshake();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_release: got %0b want 0", out_valid); end
        vectors++; if (dut.state_q !== ST_IDLE) begin miscompares++; $display("FAIL basic_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_gapped();
        open_frame();
        drive_y(9'd5);
        gap();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL gap_busy1: got %0b want 1", busy); end
        drive_y(9'd7);
        // A start pulse mid-frame must not restart accumulation.
        start = 1'b1;
        gap();
        start = 1'b0;
        gap();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL gap_busy2: got %0b want 1", busy); end
        drive_y(9'd9);
        vectors++; if (busy !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL gap_busy3: got busy=%0b valid=%0b want 1 0", busy, out_valid); end
        drive_y(9'd11);
        exp_v = exp_q.pop_front();
        vectors++; if (out_valid !== 1'b1 || out_sum !== exp_v) begin miscompares++; $display("FAIL gap_sum: got valid=%0b sum=%0d want 1 %0d", out_valid, out_sum, exp_v); end
        handshake();
    endtask

    task automatic test_backpressure();
        open_frame();
        drive_y(9'd10); drive_y(9'd20); drive_y(9'd30); drive_y(9'd40);
        exp_v = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_y     = 9'd3;
            tick();
            vectors++; if (out_valid !== 1'b1 || out_sum !== exp_v) begin miscompares++; $display("FAIL bp_hold%0d: got valid=%0b sum=%0d want 1 %0d", i, out_valid, out_sum, exp_v); end
        end
        in_valid = 1'b0;
        vectors++; if (drop_err !== 1'b1) begin miscompares++; $display("FAIL bp_drop: got %0b want 1", drop_err); end
        exp_v = exp_q.pop_front();
        vectors++; if (out_sum !== exp_v) begin miscompares++; $display("FAIL bp_sum: got %0d want %0d", out_sum, exp_v); end
        handshake();
        vectors++; if (drop_err !== 1'b1) begin miscompares++; $display("FAIL bp_drop_sticky: got %0b want 1", drop_err); end
        open_frame();
        vectors++; if (drop_err !== 1'b0) begin miscompares++; $display("FAIL bp_drop_clear: got %0b want 0", drop_err); end
        drive_y(9'd1); drive_y(9'd2); drive_y(9'd3); drive_y(9'd4);
        exp_v = exp_q.pop_front();
        vectors++; if (out_sum !== exp_v) begin miscompares++; $display("FAIL bp_next_sum: got %0d want %0d", out_sum, exp_v); end
        handshake();
    endtask

    task automatic test_max();
        logic [IN_W-1:0] y_ma;
        logic [3:0] a, b, c;
        open_frame();
        for (int i = 0; i < LEN; i++) drive_y(9'd511);
        exp_v = exp_q.pop_front();
        vectors++; if (out_sum !== exp_v || out_sum !== 11'd2044) begin miscompares++; $display("FAIL max_sum: got %0d want %0d", out_sum, exp_v); end
        handshake();
        a = 4'd15; b = 4'd15; c = 4'd15;
        y_ma = IN_W'(a * b + c);
        open_frame();
        for (int i = 0; i < LEN; i++) drive_y(y_ma);
        exp_v = exp_q.pop_front();
        vectors++; if (out_sum !== exp_v) begin miscompares++; $display("FAIL madd_sum: got %0d want %0d", out_sum, exp_v); end
        handshake();
        // Random frames with random gaps.
        for (int f = 0; f < 4; f++) begin
            open_frame();
            for (int i = 0; i < LEN; i++) begin
                if ($urandom_range(0, 1) == 1) gap();
                drive_y(IN_W'($urandom_range(0, 511)));
            end
            exp_v = exp_q.pop_front();
            vectors++; if (out_valid !== 1'b1 || out_sum !== exp_v) begin miscompares++; $display("FAIL rand_sum%0d: got valid=%0b sum=%0d want 1 %0d", f, out_valid, out_sum, exp_v); end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        open_frame();
        drive_y(9'd2); drive_y(9'd2); drive_y(9'd2); drive_y(9'd2);
        exp_v = exp_q.pop_front();
        vectors++; if (out_valid !== 1'b1 || out_sum !== exp_v) begin miscompares++; $display("FAIL b2b_first: got valid=%0b sum=%0d want 1 %0d", out_valid, out_sum, exp_v); end
        out_ready = 1'b1; start = 1'b1; in_valid = 1'b1; in_y = 9'd1;
        model_acc = ACC_W'(1);
        model_cnt = 1;
        tick();
        out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_chain: got valid=%0b busy=%0b want 0 1", out_valid, busy); end
        drive_y(9'd1); drive_y(9'd1); drive_y(9'd1);
        exp_v = exp_q.pop_front();
        vectors++; if (out_valid !== 1'b1 || out_sum !== exp_v) begin miscompares++; $display("FAIL b2b_second: got valid=%0b sum=%0d want 1 %0d", out_valid, out_sum, exp_v); end
        handshake();
        vectors++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_end: got valid=%0b pending=%0d want 0 0", out_valid, exp_q.size()); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_acc   = '0;
        model_cnt   = 0;
        rst         = 1'b1;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_y        = '0;
        out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_max();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
